multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 85 ++++++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and helpers for the multicycle processor control unit.
package ctrl_pkg;

    localparam int unsigned MAX_WAIT_MIN = 1;
    localparam int unsigned MAX_WAIT_MAX = 255;
    localparam int unsigned WAIT_W       = 8;
    localparam int unsigned INST_W       = 32;
    localparam int unsigned CNT_W        = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } op_class_t;

    typedef enum logic [1:0] {
        IMM_NONE = 2'b00,
        IMM_I    = 2'b01,
        IMM_S    = 2'b10,
        IMM_SB   = 2'b11
    } imm_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    typedef struct packed {
        logic      legal;
        op_class_t cls;
    } decode_t;

    // Classify the opcode field; anything outside the five supported classes is illegal.
    function automatic decode_t decode_opcode(input logic [6:0] opcode);
        decode_t d;
        d.legal = 1'b1;
        d.cls   = CLS_R;
        case (opcode)
            OP_R:      d.cls = CLS_R;
            OP_I:      d.cls = CLS_I;
            OP_LOAD:   d.cls = CLS_LOAD;
            OP_STORE:  d.cls = CLS_STORE;
            OP_BRANCH: d.cls = CLS_BRANCH;
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic imm_sel_t class_imm(input op_class_t cls);
        imm_sel_t sel;
        case (cls)
            CLS_I, CLS_LOAD: sel = IMM_I;
            CLS_STORE:       sel = IMM_S;
            CLS_BRANCH:      sel = IMM_SB;
            default:         sel = IMM_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags the cycle that exhausts the wait budget.
module mem_wait_timer
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_c
);

    localparam logic [WAIT_W-1:0] LAST_COUNT = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + WAIT_W'(1);
        end
    end

    // The MAX_WAIT-th consecutive waiting cycle expires; a ready in that cycle suppresses inc_i.
    assign expired_c = inc_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/multicycle_control.sv
// Control unit for a multicycle RV32 subset datapath: fetch/decode/exec/mem/wb sequencing.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              zero_i,
    input  logic              mem_ready_i,
    output logic              pc_write_o,
    output logic              ir_write_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic              alu_src_o,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic              branch_taken_o,
    output logic [1:0]        imm_sel_o,
    output logic [1:0]        alu_op_o,
    output logic [2:0]        state_o,
    output logic [1:0]        err_o,
    output logic [CNT_W-1:0]  retired_o
);

    state_t           state_q, state_d;
    op_class_t        cls_q, cls_d;
    err_t             err_q, err_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire_c;
    logic             wait_busy_c;
    logic             wait_expired_c;
    decode_t          dec_c;
    imm_sel_t         imm_sel_c;
    alu_op_t          alu_op_c;
    logic             unused_inst_c;

    assign unused_inst_c = ^inst_i[INST_W-1:7];

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!wait_busy_c || mem_ready_i),
        .inc_i     (wait_busy_c && !mem_ready_i),
        .expired_c (wait_expired_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_R;
            err_q     <= ERR_NONE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
            if (retire_c) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state and strobe decode; strobes depend on the current state and same-cycle inputs.
    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        err_d          = err_q;
        retire_c       = 1'b0;
        wait_busy_c    = 1'b0;
        pc_write_o     = 1'b0;
        ir_write_o     = 1'b0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        alu_src_o      = 1'b0;
        reg_write_o    = 1'b0;
        mem_to_reg_o   = 1'b0;
        branch_taken_o = 1'b0;
        imm_sel_c      = IMM_NONE;
        alu_op_c       = ALU_ADD;
        dec_c          = decode_opcode(inst_i[6:0]);

        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                wait_busy_c = 1'b1;
                mem_req_o   = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = ST_DECODE;
                end else if (wait_expired_c) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (dec_c.legal) begin
                    cls_d   = dec_c.cls;
                    state_d = ST_EXEC;
                end else begin
                    err_d   = ERR_ILLEGAL;
                    state_d = ST_ERROR;
                end
            end
            ST_EXEC: begin
                imm_sel_c = class_imm(cls_q);
                case (cls_q)
                    CLS_R: begin
                        alu_op_c = ALU_FUNCT;
                        state_d  = ST_WB;
                    end
                    CLS_I: begin
                        alu_src_o = 1'b1;
                        alu_op_c  = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_o = 1'b1;
                        state_d   = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op_c       = ALU_SUB;
                        pc_write_o     = zero_i;
                        branch_taken_o = zero_i;
                        retire_c       = 1'b1;
                        state_d        = start_i ? ST_FETCH : ST_IDLE;
                    end
                    default: state_d = ST_ERROR;
                endcase
            end
            ST_MEM: begin
                imm_sel_c   = class_imm(cls_q);
                wait_busy_c = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = (cls_q == CLS_STORE);
                if (mem_ready_i) begin
                    if (cls_q == CLS_STORE) begin
                        retire_c = 1'b1;
                        state_d  = start_i ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired_c) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERROR;
                end
            end
            ST_WB: begin
                imm_sel_c    = class_imm(cls_q);
                reg_write_o  = 1'b1;
                mem_to_reg_o = (cls_q == CLS_LOAD);
                retire_c     = 1'b1;
                state_d      = start_i ? ST_FETCH : ST_IDLE;
            end
            ST_ERROR: ;
            default: state_d = ST_ERROR;
        endcase
    end

    assign imm_sel_o = imm_sel_c;
    assign alu_op_o  = alu_op_c;
    assign state_o   = state_q;
    assign err_o     = err_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a transaction-level expectation model.
module tb_multicycle_control;

    localparam int unsigned MAX_WAIT = 15;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [31:0] inst_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        pc_write_o, ir_write_o, mem_req_o, mem_we_o;
    logic        alu_src_o, reg_write_o, mem_to_reg_o, branch_taken_o;
    logic [1:0]  imm_sel_o, alu_op_o, err_o;
    logic [2:0]  state_o;
    logic [31:0] retired_o;

    multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .inst_i         (inst_i),
        .zero_i         (zero_i),
        .mem_ready_i    (mem_ready_i),
        .pc_write_o     (pc_write_o),
        .ir_write_o     (ir_write_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .alu_src_o      (alu_src_o),
        .reg_write_o    (reg_write_o),
        .mem_to_reg_o   (mem_to_reg_o),
        .branch_taken_o (branch_taken_o),
        .imm_sel_o      (imm_sel_o),
        .alu_op_o       (alu_op_o),
        .state_o        (state_o),
        .err_o          (err_o),
        .retired_o      (retired_o)
    );

    typedef struct packed {
        logic [2:0]  state;
        logic        pc_write;
        logic        ir_write;
        logic        mem_req;
        logic        mem_we;
        logic        alu_src;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch_taken;
        logic [1:0]  imm_sel;
        logic [1:0]  alu_op;
        logic [1:0]  err;
        logic [31:0] retired;
    } obs_t;

    obs_t        exp_cur;
    obs_t        act_obs;
    bit          exp_valid;
    int          n_checks;
    int          n_err;
    logic [31:0] m_retired;
    logic [1:0]  m_err;
    int          state_trace[$];
    int          memreq_mem_cnt;
    int          taken_cnt;
    logic [1:0]  imm_of [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Per-cycle comparison of every output against the model's expectation.
    always @(negedge clk_i) begin
        if (exp_valid) begin
            act_obs = {state_o, pc_write_o, ir_write_o, mem_req_o, mem_we_o, alu_src_o,
                       reg_write_o, mem_to_reg_o, branch_taken_o, imm_sel_o, alu_op_o,
                       err_o, retired_o};
            n_checks++;
            if (act_obs !== exp_cur) begin
                n_err++;
                $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_obs, exp_cur);
            end
            state_trace.push_back(int'(state_o));
            if (state_o == 3'd4 && mem_req_o) memreq_mem_cnt++;
            if (branch_taken_o) taken_cnt++;
        end
    end

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o         = '0;
        o.state   = st;
        o.err     = m_err;
        o.retired = m_retired;
        return o;
    endfunction

    // 0 R, 1 I-arith, 2 load, 3 store, 4 branch, -1 illegal
    function automatic int op_kind(input logic [31:0] inst);
        case (inst[6:0])
            7'h33:   return 0;
            7'h13:   return 1;
            7'h03:   return 2;
            7'h23:   return 3;
            7'h63:   return 4;
            default: return -1;
        endcase
    endfunction

    task automatic step(input obs_t e);
        exp_cur   = e;
        exp_valid = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        exp_valid   = 1'b0;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        mem_ready_i = 1'b0;
        zero_i      = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        m_retired = '0;
        m_err     = 2'b00;
    endtask

    task automatic idle_cycle(input bit start);
        start_i     = start;
        mem_ready_i = 1'b0;
        zero_i      = 1'b0;
        step(base(3'd0));
    endtask

    task automatic fetch_phase(input int wait_n);
        obs_t e;
        for (int i = 0; i <= wait_n; i++) begin
            e           = base(3'd1);
            e.mem_req   = 1'b1;
            mem_ready_i = (i == wait_n);
            start_i     = i[0];
            if (i == wait_n) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            step(e);
        end
        mem_ready_i = 1'b0;
    endtask

    // One instruction starting in FETCH; start_i is held opposite to start_after except at the retire point.
    task automatic run_instr(input logic [31:0] inst, input int fetch_wait, input int mem_wait,
                             input bit zero, input bit start_after);
        int   k;
        obs_t e;
        k = op_kind(inst);
        fetch_phase(fetch_wait);
        inst_i      = inst;
        mem_ready_i = 1'b0;
        start_i     = !start_after;
        step(base(3'd2));
        if (k < 0) begin
            m_err = 2'b01;
            return;
        end
        e         = base(3'd3);
        e.imm_sel = imm_of[k];
        zero_i    = zero;
        case (k)
            0: e.alu_op = 2'd2;
            1: begin e.alu_src = 1'b1; e.alu_op = 2'd2; end
            2, 3: begin e.alu_src = 1'b1; e.alu_op = 2'd0; end
            default: begin
                e.alu_op = 2'd1;
                if (zero) begin
                    e.pc_write     = 1'b1;
                    e.branch_taken = 1'b1;
                end
                start_i = start_after;
            end
        endcase
        step(e);
        zero_i = 1'b0;
        if (k == 4) begin
            m_retired++;
            return;
        end
        if (k == 2 || k == 3) begin
            for (int i = 0; i <= mem_wait; i++) begin
                e           = base(3'd4);
                e.imm_sel   = imm_of[k];
                e.mem_req   = 1'b1;
                e.mem_we    = (k == 3);
                mem_ready_i = (i == mem_wait);
                start_i     = (i == mem_wait) ? start_after : !start_after;
                step(e);
            end
            mem_ready_i = 1'b0;
            if (k == 3) begin
                m_retired++;
                return;
            end
        end
        e            = base(3'd5);
        e.imm_sel    = imm_of[k];
        e.reg_write  = 1'b1;
        e.mem_to_reg = (k == 2);
        start_i      = start_after;
        step(e);
        m_retired++;
    endtask

    task automatic error_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start_i     = 1'b1;
            mem_ready_i = i[0];
            zero_i      = 1'b1;
            step(base(3'd6));
        end
        mem_ready_i = 1'b0;
        zero_i      = 1'b0;
    endtask

    initial begin
        obs_t e;
        logic [31:0] tv;
        n_checks = 0;
        n_err = 0;
        exp_valid = 1'b0;
        rst_i = 1'b1;
        start_i = 1'b0;
        inst_i = '0;
        zero_i = 1'b0;
        mem_ready_i = 1'b0;
        m_retired = '0;
        m_err = 2'b00;
        memreq_mem_cnt = 0;
        taken_cnt = 0;

        do_reset();
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_strobes", 32'({pc_write_o, ir_write_o, mem_req_o, mem_we_o, alu_src_o, reg_write_o,
                                  mem_to_reg_o, branch_taken_o, imm_sel_o, alu_op_o, err_o}), 32'd0);
        chk("reset_retired", retired_o, 32'd0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // add x3,x1,x2 with immediate ready
        state_trace.delete();
        run_instr(32'h002081B3, 0, 0, 1'b1, 1'b1);
        tv = 32'(state_trace[0] * 4096 + state_trace[1] * 256 + state_trace[2] * 16 + state_trace[3]);
        chk("add_trace", tv, 32'h1235);
        chk("add_trace_len", 32'(state_trace.size()), 32'd4);
        chk("add_next_state", 32'(state_o), 32'd1);
        chk("add_retired", retired_o, 32'd1);

        // lw with three wait cycles in MEM
        memreq_mem_cnt = 0;
        run_instr(32'h0000A103, 0, 3, 1'b0, 1'b1);
        chk("lw_mem_req_cycles", 32'(memreq_mem_cnt), 32'd4);
        chk("lw_retired", retired_o, 32'd2);

        taken_cnt = 0;
        run_instr(32'h00000463, 0, 0, 1'b1, 1'b1);
        chk("beq_taken_count", 32'(taken_cnt), 32'd1);
        chk("beq_next_state", 32'(state_o), 32'd1);
        taken_cnt = 0;
        run_instr(32'h00000463, 1, 0, 1'b0, 1'b1);
        chk("beq_not_taken_count", 32'(taken_cnt), 32'd0);

        // ready on the last permitted wait cycle must win over the timeout
        run_instr(32'h00108093, 14, 0, 1'b0, 1'b1);
        chk("fetch_ready_precedence_err", 32'(err_o), 32'd0);
        run_instr(32'h0020A023, 0, 14, 1'b0, 1'b0);
        chk("sw_retired", retired_o, 32'd6);
        chk("sw_to_idle", 32'(state_o), 32'd0);
        idle_cycle(1'b0);

        // counter wrap
        exp_valid = 1'b0;
        force dut.retired_q = 32'hFFFFFFFF;
        @(posedge clk_i);
        #1;
        release dut.retired_q;
        m_retired = 32'hFFFFFFFF;
        chk("forced_retired", retired_o, 32'hFFFFFFFF);
        idle_cycle(1'b1);
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b1);
        chk("wrap_retired", retired_o, 32'd0);

        // reset in MEM of sw, with ready arriving in the same cycle
        fetch_phase(0);
        inst_i  = 32'h0020A023;
        start_i = 1'b1;
        step(base(3'd2));
        e = base(3'd3);
        e.imm_sel = 2'd2;
        e.alu_src = 1'b1;
        step(e);
        e = base(3'd4);
        e.imm_sel = 2'd2;
        e.mem_req = 1'b1;
        e.mem_we  = 1'b1;
        step(e);
        exp_valid   = 1'b0;
        rst_i       = 1'b1;
        mem_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        mem_ready_i = 1'b0;
        start_i     = 1'b0;
        m_retired   = '0;
        chk("rst_mem_state", 32'(state_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_retired", retired_o, 32'd0);
        idle_cycle(1'b0);

        // illegal opcode
        idle_cycle(1'b1);
        run_instr(32'h0000007F, 0, 0, 1'b0, 1'b1);
        error_cycles(3);
        chk("illegal_err", 32'(err_o), 32'd1);
        chk("illegal_state", 32'(state_o), 32'd6);
        do_reset();
        idle_cycle(1'b1);

        // fetch timeout
        for (int i = 0; i < int'(MAX_WAIT); i++) begin
            e = base(3'd1);
            e.mem_req = 1'b1;
            mem_ready_i = 1'b0;
            start_i = 1'b0;
            step(e);
        end
        m_err = 2'b10;
        error_cycles(4);
        chk("timeout_err", 32'(err_o), 32'd2);
        chk("timeout_state", 32'(state_o), 32'd6);
        do_reset();
        idle_cycle(1'b0);
        chk("final_err_cleared", 32'(err_o), 32'd0);

        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
